// File: rtl/dft2_input_commutator.sv
// Input commutator for the radix-2 DFT butterfly: buffers the first half of
// each N-point frame and emits (x[k], x[k+N/2], k) pairs on a registered output.
module dft2_input_commutator #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [IW-1:0] out_index,
    output logic          out_last
);

    localparam int CW   = $clog2(N);
    localparam int KW   = CW - 1;
    localparam int HALF = N / 2;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_e;

    state_e        state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k;
    logic [DW-1:0] buf_q [HALF];

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_a_q, out_a_d;
    logic [DW-1:0] out_b_q, out_b_d;
    logic [IW-1:0] out_index_q, out_index_d;
    logic          out_last_q, out_last_d;

    logic          in_xfer;
    logic          out_xfer;

    // State is the counter MSB; the low bits are the pair index in PAIR.
    always_comb begin
        state    = state_e'(cnt_q[CW-1]);
        k        = cnt_q[KW-1:0];
        in_ready = (state == FILL) || !out_valid_q || out_ready;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid_q && out_ready;
    end

    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end
        if (in_xfer) begin
            cnt_d = cnt_q + CW'(1);
            if (state == PAIR) begin
                out_valid_d = 1'b1;
                out_a_d     = buf_q[k];
                out_b_d     = in_data;
                out_index_d = IW'(k);
                out_last_d  = &k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    // Buffer holds no reset value; entries are always written before being read.
    always_ff @(posedge clk) begin
        if (in_xfer && state == FILL) begin
            buf_q[k] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dft2_input_commutator.sv
// Randomized bench for dft2_input_commutator, checked every cycle against a
// frame-position reference model.
module tb_dft2_input_commutator;

    localparam int N    = 8;
    localparam int DW   = 8;
    localparam int IW   = 3;
    localparam int HALF = N / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [IW-1:0] out_index;
    logic          out_last;

    always #5 clk = ~clk;

    dft2_input_commutator #(
        .N (N),
        .DW(DW),
        .IW(IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_index(out_index),
        .out_last (out_last)
    );

    // Reference model: position within the frame, stored first half, pending pair.
    int            pos;
    logic [DW-1:0] frame [HALF];
    bit            m_ov;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    int            m_k;
    bit            m_last;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(m_ov));
        check_eq("out_a",     32'(out_a),     32'(m_a));
        check_eq("out_b",     32'(out_b),     32'(m_b));
        check_eq("out_index", 32'(out_index), 32'(m_k));
        check_eq("out_last",  32'(out_last),  32'(m_last));
    endtask

    task automatic model_reset();
        pos    = 0;
        m_ov   = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_k    = 0;
        m_last = 1'b0;
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit r, output bit acc);
        bit exp_rdy;
        bit out_x;
        @(negedge clk);
        compare_outputs();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        exp_rdy = (pos < HALF) || !m_ov || r;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc   = v && exp_rdy;
        out_x = m_ov && r;
        @(posedge clk);
        if (out_x) m_ov = 1'b0;
        if (acc) begin
            if (pos < HALF) begin
                frame[pos] = d;
            end else begin
                m_k    = pos - HALF;
                m_a    = frame[m_k];
                m_b    = d;
                m_last = (m_k == HALF - 1);
                m_ov   = 1'b1;
            end
            pos = (pos + 1) % N;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    endtask

    // mode 0: streaming; 1: alternate valid; 2: 3-cycle stall from cycle 5;
    // 4: valid with out_ready low; otherwise random handshakes and data.
    task automatic feed(input logic [DW-1:0] base, input int n, input int mode);
        int            sent = 0;
        int            cyc  = 0;
        bit            v;
        bit            r;
        bit            acc;
        logic [DW-1:0] d;
        while (sent < n) begin
            if (cyc >= 64 * n) begin
                check_eq("feed_timeout", 32'(sent), 32'(n));
                return;
            end
            d = base + DW'(sent);
            case (mode)
                0: begin v = 1'b1; r = 1'b1; end
                1: begin v = (cyc % 2 == 0); r = 1'b1; end
                2: begin v = 1'b1; r = !(cyc >= 5 && cyc < 8); end
                4: begin v = 1'b1; r = 1'b0; end
                default: begin
                    v = ($urandom_range(0, 3) != 0);
                    r = ($urandom_range(0, 2) != 0);
                    d = DW'($urandom);
                end
            endcase
            step(v, d, r, acc);
            if (acc) sent++;
            cyc++;
        end
    endtask

    task automatic idle(input int n, input bit r);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, r, acc);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Basic frame, then back-to-back second frame
        feed(8'h10, 8, 0);
        feed(8'h20, 8, 0);
        idle(2, 1'b1);

        // Output backpressure
        feed(8'h10, 8, 2);
        idle(2, 1'b1);

        // Input gaps
        feed(8'h10, 8, 1);
        idle(2, 1'b1);

        // Reset mid-frame with a pair pending
        feed(8'h10, 6, 0);
        check_eq("pre_rst_pending", 32'(out_valid), 32'd1);
        do_reset();
        feed(8'h30, 8, 0);
        idle(2, 1'b1);

        // FILL under stall: last pair of a frame held while next frame fills
        feed(8'h10, 8, 0);
        feed(8'h40, 4, 4);
        idle(2, 1'b1);
        feed(8'h44, 4, 0);
        idle(2, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            feed('0, $urandom_range(1, 16), 3);
        end
        idle(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
